// File: rtl/signed_divider_seq_pkg.sv
// Shared types and helpers for the sequential signed divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Widest operand the magnitude helper supports.
  localparam int unsigned ABS_W = 64;

  // Bits needed to represent values 0..v-1 (ceil(log2(v))).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Two's-complement magnitude of a sign-extended value; callers truncate
  // to their own width, so the most negative N-bit value maps to 2^(N-1).
  function automatic logic [ABS_W-1:0] abs_n(input logic [ABS_W-1:0] v);
    return v[ABS_W-1] ? ((~v) + ABS_W'(1)) : v;
  endfunction

endpackage

// File: rtl/signed_divider_seq_if.sv
// Load/result bus of the sequential signed divider.
interface signed_divider_seq_if #(
  parameter int unsigned N = 8
);
  logic         load;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         busy;
  logic         done;
  logic         dz;
  logic         ovf;

  modport master (
    output load, A, B,
    input  Q, R, busy, done, dz, ovf
  );

  modport slave (
    input  load, A, B,
    output Q, R, busy, done, dz, ovf
  );
endinterface

// File: rtl/signed_divider_seq_restoring_div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module restoring_div_step #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] i_rem,
  input  logic         i_msb,
  input  logic [N-1:0] i_bmag,
  output logic [N-1:0] o_rem,
  output logic         o_qbit
);
  logic [N:0] w_shift;
  logic [N:0] w_trial;

  // Shift next dividend bit into the remainder and trial-subtract |B|;
  // bit N of the difference is the borrow that selects restore.
  always_comb begin
    w_shift = {i_rem, i_msb};
    w_trial = w_shift - {1'b0, i_bmag};
    o_qbit  = ~w_trial[N];
    o_rem   = w_trial[N] ? w_shift[N-1:0] : w_trial[N-1:0];
  end
endmodule

// File: rtl/signed_divider_seq.sv
// Sequential signed divider: radix-2 restoring on magnitudes, then sign fixup.
// Fixed latency of N+1 clocks from the load edge to done.
module signed_divider_seq #(
  parameter int unsigned N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  signed_divider_seq_if.slave  bus
);
  import divider_pkg::*;

  localparam int unsigned   CW      = clog2(N + 1);
  localparam logic [N-1:0]  MIN_VAL = {1'b1, {(N-1){1'b0}}};

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_rem;
  logic [N-1:0]   r_dvd;
  logic [N-1:0]   r_bmag;
  logic [N-1:0]   r_a_orig;
  logic           r_sa;
  logic           r_sb;
  logic [N-1:0]   r_q;
  logic [N-1:0]   r_r;
  logic           r_busy;
  logic           r_done;
  logic           r_dz;
  logic           r_ovf;

  logic [N-1:0]   w_next_rem;
  logic           w_qbit;
  logic [N-1:0]   w_amag;
  logic [N-1:0]   w_bmag;

  // Operand magnitudes; -2^(N-1) becomes the unsigned value 2^(N-1).
  always_comb begin
    w_amag = N'(abs_n(ABS_W'($signed(bus.A))));
    w_bmag = N'(abs_n(ABS_W'($signed(bus.B))));
  end

  restoring_div_step #(.N(N)) u_step (
    .i_rem  (r_rem),
    .i_msb  (r_dvd[N-1]),
    .i_bmag (r_bmag),
    .o_rem  (w_next_rem),
    .o_qbit (w_qbit)
  );

  // Control FSM, iteration counter, datapath registers and result fixup.
  // r_dvd shifts the dividend out of its MSB while quotient bits enter at
  // the LSB, so after N iterations it holds |Q|.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_bmag   <= '0;
      r_a_orig <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_q      <= '0;
      r_r      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.load) begin
            r_dvd    <= w_amag;
            r_bmag   <= w_bmag;
            r_a_orig <= bus.A;
            r_sa     <= bus.A[N-1];
            r_sb     <= bus.B[N-1];
            r_dz     <= (bus.B == '0);
            r_ovf    <= (bus.A == MIN_VAL) && (bus.B == '1);
            r_rem    <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= CALC;
          end
        end
        CALC: begin
          r_rem <= w_next_rem;
          r_dvd <= {r_dvd[N-2:0], w_qbit};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) r_state <= FIX;
        end
        FIX: begin
          if (r_dz) begin
            r_q <= '1;
            r_r <= r_a_orig;
          end else if (r_ovf) begin
            r_q <= MIN_VAL;
            r_r <= '0;
          end else begin
            r_q <= (r_sa ^ r_sb) ? ('0 - r_dvd) : r_dvd;
            r_r <= r_sa ? ('0 - r_rem) : r_rem;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.Q    = r_q;
  assign bus.R    = r_r;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.dz   = r_dz;
  assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_signed_divider_seq.sv
// Directed bench for signed_divider_seq (N=8).
module tb_signed_divider_seq;

  localparam int unsigned N = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ovf;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  signed_divider_seq_if #(.N(N)) dif ();

  signed_divider_seq #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Load at edge 0, follow N+1 edges; lat_ok clears if busy/done deviate
  // before the final edge. Returns sampled #1 after edge N+1.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output logic lat_ok);
    lat_ok = 1'b1;
    @(negedge clk);
    dif.load = 1'b1;
    dif.A    = a;
    dif.B    = b;
    @(posedge clk);
    #1;
    dif.load = 1'b0;
    if (!(dif.busy === 1'b1 && dif.done === 1'b0)) lat_ok = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (!(dif.busy === 1'b1 && dif.done === 1'b0)) lat_ok = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vecs[$];
    logic lat;

    checks   = 0;
    failures = 0;
    dif.load = 1'b0;
    dif.A    = '0;
    dif.B    = '0;
    rst      = 1'b0;

    vecs.push_back('{8'd15,  8'd4,   8'h03, 8'h03, 1'b0, 1'b0});
    vecs.push_back('{8'hF1,  8'd4,   8'hFD, 8'hFD, 1'b0, 1'b0});
    vecs.push_back('{8'd15,  8'hFC,  8'hFD, 8'h03, 1'b0, 1'b0});
    vecs.push_back('{8'hF1,  8'hFC,  8'h03, 8'hFD, 1'b0, 1'b0});
    vecs.push_back('{8'd7,   8'd0,   8'hFF, 8'h07, 1'b1, 1'b0});
    vecs.push_back('{8'd6,   8'd3,   8'h02, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{8'h80,  8'h01,  8'h80, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{8'h7F,  8'h80,  8'h00, 8'h7F, 1'b0, 1'b0});
    vecs.push_back('{8'h80,  8'h80,  8'h01, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0});
    vecs.push_back('{8'hFF,  8'd2,   8'h00, 8'hFF, 1'b0, 1'b0});
    vecs.push_back('{8'd0,   8'd5,   8'h00, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{8'hF9,  8'd0,   8'hFF, 8'hF9, 1'b1, 1'b0});

    // Reset state
    #12;
    chk("reset_Q",    dif.Q, 8'h00);
    chk("reset_R",    dif.R, 8'h00);
    chk("reset_busy", {7'd0, dif.busy}, 8'h00);
    chk("reset_done", {7'd0, dif.done}, 8'h00);
    chk("reset_dz",   {7'd0, dif.dz},   8'h00);
    chk("reset_ovf",  {7'd0, dif.ovf},  8'h00);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven vectors
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), {7'd0, lat}, 8'h01);
      chk($sformatf("v%0d_done", i), {7'd0, dif.done}, 8'h01);
      chk($sformatf("v%0d_busy", i), {7'd0, dif.busy}, 8'h00);
      chk($sformatf("v%0d_Q", i), dif.Q, vecs[i].q);
      chk($sformatf("v%0d_R", i), dif.R, vecs[i].r);
      chk($sformatf("v%0d_dz", i), {7'd0, dif.dz}, {7'd0, vecs[i].dz});
      chk($sformatf("v%0d_ovf", i), {7'd0, dif.ovf}, {7'd0, vecs[i].ovf});
    end

    // DONE holds results while idle
    repeat (3) @(posedge clk);
    #1;
    chk("hold_Q",    dif.Q, 8'hFF);
    chk("hold_R",    dif.R, 8'hF9);
    chk("hold_dz",   {7'd0, dif.dz}, 8'h01);
    chk("hold_done", {7'd0, dif.done}, 8'h01);

    // Load during CALC is ignored; operand changes during CALC are harmless
    @(negedge clk);
    dif.load = 1'b1; dif.A = 8'd100; dif.B = 8'd7;
    @(posedge clk);
    #1;
    dif.load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    dif.load = 1'b1; dif.A = 8'd1; dif.B = 8'd1;
    @(posedge clk);
    #1;
    dif.load = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("ign_not_done_e8", {7'd0, dif.done}, 8'h00);
    @(posedge clk);
    #1;
    chk("ign_done", {7'd0, dif.done}, 8'h01);
    chk("ign_Q", dif.Q, 8'h0E);
    chk("ign_R", dif.R, 8'h02);

    // Asynchronous reset mid-operation
    @(negedge clk);
    dif.load = 1'b1; dif.A = 8'd100; dif.B = 8'd7;
    @(posedge clk);
    #1;
    dif.load = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_Q",    dif.Q, 8'h00);
    chk("arst_R",    dif.R, 8'h00);
    chk("arst_busy", {7'd0, dif.busy}, 8'h00);
    chk("arst_done", {7'd0, dif.done}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    run_op(8'd9, 8'd2, lat);
    chk("post_rst_latency", {7'd0, lat}, 8'h01);
    chk("post_rst_Q", dif.Q, 8'h04);
    chk("post_rst_R", dif.R, 8'h01);

    // load held high restarts from DONE with the current operands
    @(negedge clk);
    dif.load = 1'b1; dif.A = 8'd6; dif.B = 8'd3;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    chk("held1_done", {7'd0, dif.done}, 8'h01);
    chk("held1_Q", dif.Q, 8'h02);
    chk("held1_R", dif.R, 8'h00);
    dif.A = 8'hF9; dif.B = 8'd2;
    @(posedge clk);
    #1;
    chk("held2_restart_busy", {7'd0, dif.busy}, 8'h01);
    chk("held2_restart_done", {7'd0, dif.done}, 8'h00);
    repeat (9) @(posedge clk);
    #1;
    dif.load = 1'b0;
    chk("held2_done", {7'd0, dif.done}, 8'h01);
    chk("held2_Q", dif.Q, 8'hFD);
    chk("held2_R", dif.R, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
